// File: rtl/mem_stage_sram_if.sv
// mem_stage_sram_if
//   Bundles the execute->memory pipeline inputs, the memory->writeback
//   register outputs, the stall handshake and the external 16-bit SRAM bus
//   into one interface.
// Modports
//   master : the environment side. It is upstream pipeline plus SRAM device.
//            It drives the pipeline inputs and sram_rdata, and observes all
//            other signals.
//   slave  : the memory stage itself.
// Signals
//   wb_en_in, mem_r_en_in, mem_w_en_in : control bits from execute
//   alu_res_in [31:0]                  : ALU result / memory address
//   val_Rm_in  [31:0]                  : store data
//   dest_in    [3:0]                   : destination register
//   ready                              : low = upstream must freeze
//   sram_addr [17:0], sram_wdata [15:0], sram_rdata [15:0], sram_we_n
//   wb_en_out, mem_r_en_out, dest_out [3:0], alu_res_out [31:0],
//   mem_data_out [31:0]                : registered writeback-stage outputs
interface mem_stage_sram_if;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_Rm_in;
  logic [3:0]  dest_in;

  logic        ready;

  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;

  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out;
  logic [31:0] mem_data_out;

  modport master (
    output wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_Rm_in, dest_in,
    output sram_rdata,
    input  ready, sram_addr, sram_wdata, sram_we_n,
    input  wb_en_out, mem_r_en_out, dest_out, alu_res_out, mem_data_out
  );

  modport slave (
    input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_Rm_in, dest_in,
    input  sram_rdata,
    output ready, sram_addr, sram_wdata, sram_we_n,
    output wb_en_out, mem_r_en_out, dest_out, alu_res_out, mem_data_out
  );
endinterface

// File: rtl/mem_stage_sram.sv
// mem_stage_sram
//   Pipeline memory stage for a 32-bit core in front of an external 16-bit
//   SRAM. Each 32-bit load or store is split into a low halfword access and
//   a high halfword access. Each access is held for SRAM_WAIT+1 cycles. While
//   an access is in progress, ready is held low. The stage then feeds bubbles
//   to writeback until the access completes.
// Parameters
//   SRAM_WAIT : extra hold cycles per halfword access
//   MEM_BASE  : subtracted from the ALU result to form the data-memory offset
// Ports
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : mem_stage_sram_if.slave. It carries the pipeline inputs, ready, the
//         SRAM bus and the registered writeback outputs.
module mem_stage_sram #(
  parameter int SRAM_WAIT = 1,
  parameter int MEM_BASE  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_if.slave       bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CNT_W    = (SRAM_WAIT < 1) ? 1 : $clog2(SRAM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT);
  localparam logic [18:0]     BASE_LOW = 19'(MEM_BASE);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_waitCnt;
  logic [31:0]      r_dataBuf;

  logic             r_wbEnOut;
  logic             r_memREnOut;
  logic [3:0]       r_destOut;
  logic [31:0]      r_aluResOut;
  logic [31:0]      r_memDataOut;

  logic             w_memReq;
  logic             w_isRead;
  logic             w_lastCycle;
  logic             w_ready;
  logic [16:0]      w_wordIdx;
  logic [17:0]      w_sramAddr;
  logic [15:0]      w_sramWdata;
  logic             w_sramWeN;

  // A request with both enables set is a write, so it never captures read data.
  assign w_memReq    = bus.mem_r_en_in | bus.mem_w_en_in;
  assign w_isRead    = bus.mem_r_en_in & ~bus.mem_w_en_in;
  assign w_lastCycle = (r_waitCnt == CNT_LAST);

  // Only offset bits [18:2] matter. Subtracting on the low 19 bits gives the
  // same result as a 32-bit wrapping subtract followed by that slice.
  assign w_wordIdx = 17'((bus.alu_res_in[18:0] - BASE_LOW) >> 2);

  // ready drops in the same cycle that a request is seen in IDLE.
  // Reset masks request decoding so that ready reads 1 while rst is high.
  always_comb begin
    w_ready = 1'b1;
    if (!rst) begin
      case (r_state)
        S_IDLE:  w_ready = ~w_memReq;
        S_LO:    w_ready = 1'b0;
        S_HI:    w_ready = 1'b0;
        default: w_ready = 1'b1;
      endcase
    end
  end

  // The SRAM bus is driven only in LO and HI. It is parked at zero with
  // writes disabled otherwise.
  always_comb begin
    w_sramAddr  = '0;
    w_sramWdata = '0;
    w_sramWeN   = 1'b1;
    case (r_state)
      S_LO: begin
        w_sramAddr  = {w_wordIdx, 1'b0};
        w_sramWdata = bus.val_Rm_in[15:0];
        w_sramWeN   = ~bus.mem_w_en_in;
      end
      S_HI: begin
        w_sramAddr  = {w_wordIdx, 1'b1};
        w_sramWdata = bus.val_Rm_in[31:16];
        w_sramWeN   = ~bus.mem_w_en_in;
      end
      default: begin
        w_sramAddr  = '0;
        w_sramWdata = '0;
        w_sramWeN   = 1'b1;
      end
    endcase
  end

  // Access sequencer. The wait counter restarts on every state entry.
  // Read data is captured on the last hold cycle of each half, when the
  // SRAM has had the full SRAM_WAIT+1 cycles to respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_waitCnt <= '0;
      r_dataBuf <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_waitCnt <= '0;
          if (w_memReq) r_state <= S_LO;
        end
        S_LO: begin
          if (w_lastCycle) begin
            if (w_isRead) r_dataBuf[15:0] <= bus.sram_rdata;
            r_state   <= S_HI;
            r_waitCnt <= '0;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        S_HI: begin
          if (w_lastCycle) begin
            if (w_isRead) r_dataBuf[31:16] <= bus.sram_rdata;
            r_state   <= S_DONE;
            r_waitCnt <= '0;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_waitCnt <= '0;
        end
      endcase
    end
  end

  // Writeback register. It takes the held instruction whenever ready is
  // high. It takes a bubble (enables cleared, payload held) while stalled.
  // mem_data_out changes only when a read completes in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbEnOut    <= 1'b0;
      r_memREnOut  <= 1'b0;
      r_destOut    <= '0;
      r_aluResOut  <= '0;
      r_memDataOut <= '0;
    end else if (w_ready) begin
      r_wbEnOut   <= bus.wb_en_in;
      r_memREnOut <= bus.mem_r_en_in;
      r_destOut   <= bus.dest_in;
      r_aluResOut <= bus.alu_res_in;
      if ((r_state == S_DONE) && w_isRead) r_memDataOut <= r_dataBuf;
    end else begin
      r_wbEnOut   <= 1'b0;
      r_memREnOut <= 1'b0;
    end
  end

  assign bus.ready        = w_ready;
  assign bus.sram_addr    = w_sramAddr;
  assign bus.sram_wdata   = w_sramWdata;
  assign bus.sram_we_n    = w_sramWeN;
  assign bus.wb_en_out    = r_wbEnOut;
  assign bus.mem_r_en_out = r_memREnOut;
  assign bus.dest_out     = r_destOut;
  assign bus.alu_res_out  = r_aluResOut;
  assign bus.mem_data_out = r_memDataOut;

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram
//   Directed bench for mem_stage_sram. Two instances are built: SRAM_WAIT=1
//   (the default) and SRAM_WAIT=3. Each instance has its own SRAM model.
//   'sel' picks which instance receives requests and which instance is
//   observed. Expected writeback records are queued as instructions are
//   presented, and are popped when the stage accepts them. A reference copy
//   of SRAM contents supplies the expected load data.
module tb_mem_stage_sram;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic [3:0]  dest;
    logic [31:0] alu;
    logic [31:0] data;
  } outRec_t;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic preload;

  logic        tbWb, tbMr, tbMw;
  logic [31:0] tbAlu, tbRm;
  logic [3:0]  tbDest;

  logic        obsReady, obsWeN, obsWb, obsMr;
  logic [17:0] obsAddr;
  logic [15:0] obsWdata;
  logic [3:0]  obsDest;
  logic [31:0] obsAlu, obsData;

  logic [15:0] sram0 [64];
  logic [15:0] sram1 [64];
  logic [15:0] refMem [64];

  outRec_t expQ[$];
  outRec_t lastExp;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  mem_stage_sram_if bus0 ();
  mem_stage_sram_if bus1 ();

  mem_stage_sram #(.SRAM_WAIT(1), .MEM_BASE(1024)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mem_stage_sram #(.SRAM_WAIT(3), .MEM_BASE(1024)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  assign bus0.wb_en_in    = tbWb & ~sel;
  assign bus0.mem_r_en_in = tbMr & ~sel;
  assign bus0.mem_w_en_in = tbMw & ~sel;
  assign bus0.alu_res_in  = tbAlu;
  assign bus0.val_Rm_in   = tbRm;
  assign bus0.dest_in     = tbDest;
  assign bus0.sram_rdata  = sram0[bus0.sram_addr[5:0]];

  assign bus1.wb_en_in    = tbWb & sel;
  assign bus1.mem_r_en_in = tbMr & sel;
  assign bus1.mem_w_en_in = tbMw & sel;
  assign bus1.alu_res_in  = tbAlu;
  assign bus1.val_Rm_in   = tbRm;
  assign bus1.dest_in     = tbDest;
  assign bus1.sram_rdata  = sram1[bus1.sram_addr[5:0]];

  assign obsReady = sel ? bus1.ready        : bus0.ready;
  assign obsWeN   = sel ? bus1.sram_we_n    : bus0.sram_we_n;
  assign obsAddr  = sel ? bus1.sram_addr    : bus0.sram_addr;
  assign obsWdata = sel ? bus1.sram_wdata   : bus0.sram_wdata;
  assign obsWb    = sel ? bus1.wb_en_out    : bus0.wb_en_out;
  assign obsMr    = sel ? bus1.mem_r_en_out : bus0.mem_r_en_out;
  assign obsDest  = sel ? bus1.dest_out     : bus0.dest_out;
  assign obsAlu   = sel ? bus1.alu_res_out  : bus0.alu_res_out;
  assign obsData  = sel ? bus1.mem_data_out : bus0.mem_data_out;

  function automatic logic [15:0] initVal(input logic [5:0] idx);
    case (idx)
      6'd4:    initVal = 16'h5678;
      6'd5:    initVal = 16'h1234;
      default: initVal = {8'hA5, 2'b00, idx};
    endcase
  endfunction

  // SRAM models: combinational read, write on the rising edge while we_n is low.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) sram0[i] <= initVal(6'(i));
    end else if (!bus0.sram_we_n) begin
      sram0[bus0.sram_addr[5:0]] <= bus0.sram_wdata;
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) sram1[i] <= initVal(6'(i));
    end else if (!bus1.sram_we_n) begin
      sram1[bus1.sram_addr[5:0]] <= bus1.sram_wdata;
    end
  end

  task automatic resetRefMem();
    for (int i = 0; i < 64; i++) refMem[i] = initVal(6'(i));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wb"},   32'(obsWb),   32'd0);
    checkOutput({tag, "_mr"},   32'(obsMr),   32'd0);
    checkOutput({tag, "_dest"}, 32'(obsDest), 32'd0);
    checkOutput({tag, "_alu"},  obsAlu,       32'd0);
    checkOutput({tag, "_data"}, obsData,      32'd0);
  endtask

  // One clock cycle. At the falling edge it checks ready and the SRAM bus
  // against the expected values. After the rising edge it checks the
  // writeback register: an accepted instruction must appear, and otherwise
  // a bubble with the payload held.
  task automatic tick(input logic expReady, input logic [17:0] expAddr,
                      input logic [15:0] expWdata, input logic expWeN,
                      output logic wasReady);
    @(negedge clk);
    wasReady = obsReady;
    checkOutput("ready",      32'(obsReady), 32'(expReady));
    checkOutput("sram_addr",  32'(obsAddr),  32'(expAddr));
    checkOutput("sram_wdata", 32'(obsWdata), 32'(expWdata));
    checkOutput("sram_we_n",  32'(obsWeN),   32'(expWeN));
    @(posedge clk);
    #1;
    if (wasReady) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $error("[TB] FAIL accept: observed an acceptance, expected none pending");
      end else begin
        lastExp = expQ.pop_front();
        checkOutput("wb_en_out",    32'(obsWb),   32'(lastExp.wb));
        checkOutput("mem_r_en_out", 32'(obsMr),   32'(lastExp.mr));
        checkOutput("dest_out",     32'(obsDest), 32'(lastExp.dest));
        checkOutput("alu_res_out",  obsAlu,       lastExp.alu);
        checkOutput("mem_data_out", obsData,      lastExp.data);
      end
    end else begin
      checkOutput("bubble_wb",   32'(obsWb),   32'd0);
      checkOutput("bubble_mr",   32'(obsMr),   32'd0);
      checkOutput("bubble_dest", 32'(obsDest), 32'(lastExp.dest));
      checkOutput("bubble_alu",  obsAlu,       lastExp.alu);
      checkOutput("bubble_data", obsData,      lastExp.data);
    end
  endtask

  // Presents one instruction and holds it until the stage accepts it. The
  // stall window is checked cycle by cycle: one detect cycle in IDLE, then
  // W+1 cycles of LO, then W+1 cycles of HI, then ready high in DONE.
  task automatic applyStimulus(input logic wb, input logic mr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] rm,
                               input logic [3:0] dest);
    int          w;
    logic [31:0] off;
    logic [16:0] idx;
    logic [5:0]  loIdx, hiIdx;
    outRec_t     e;
    logic        memOp;
    logic        accepted;
    logic        expReady, expWeN;
    logic [17:0] expAddr;
    logic [15:0] expWdata;

    w     = sel ? 3 : 1;
    off   = alu - 32'd1024;
    idx   = off[18:2];
    loIdx = {idx[4:0], 1'b0};
    hiIdx = {idx[4:0], 1'b1};
    memOp = mr | mw;

    e.wb   = wb;
    e.mr   = mr;
    e.dest = dest;
    e.alu  = alu;
    e.data = (mr && !mw) ? {refMem[hiIdx], refMem[loIdx]} : lastExp.data;
    if (mw) begin
      refMem[loIdx] = rm[15:0];
      refMem[hiIdx] = rm[31:16];
    end

    tbWb = wb; tbMr = mr; tbMw = mw; tbAlu = alu; tbRm = rm; tbDest = dest;
    expQ.push_back(e);

    accepted = 1'b0;
    for (int cyc = 0; cyc < 64 && !accepted; cyc++) begin
      expAddr  = '0;
      expWdata = '0;
      expWeN   = 1'b1;
      if (!memOp) begin
        expReady = 1'b1;
      end else if (cyc == 0) begin
        expReady = 1'b0;
      end else if (cyc <= w + 1) begin
        expReady = 1'b0;
        expAddr  = {idx, 1'b0};
        expWdata = rm[15:0];
        expWeN   = ~mw;
      end else if (cyc <= 2 * w + 2) begin
        expReady = 1'b0;
        expAddr  = {idx, 1'b1};
        expWdata = rm[31:16];
        expWeN   = ~mw;
      end else begin
        expReady = 1'b1;
      end
      tick(expReady, expAddr, expWdata, expWeN, accepted);
    end
    if (!accepted) begin
      nCompared++;
      nMismatched++;
      $error("[TB] FAIL stall_bound: observed ready low for 64 cycles, expected %0d", 2 * w + 3);
      expQ.delete();
    end
  endtask

  initial begin
    sel = 1'b0; preload = 1'b1; rst = 1'b1;
    tbWb = 1'b0; tbMr = 1'b1; tbMw = 1'b0;
    tbAlu = 32'd1032; tbRm = 32'd0; tbDest = 4'd0;
    lastExp = '0;
    resetRefMem();

    $display("[TB] reset with a read request pending");
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_ready", 32'(obsReady), 32'd1);
    @(posedge clk);
    #1;
    checkAllZero("rst");
    checkOutput("rst_we_n", 32'(obsWeN),  32'd1);
    checkOutput("rst_addr", 32'(obsAddr), 32'd0);
    preload = 1'b0;
    rst     = 1'b0;
    tbMr    = 1'b0;

    $display("[TB] ALU op, store, loads, back-to-back");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_002A, 32'd0,          4'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1028,      32'hDEAD_BEEF,  4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1032,      32'd0,          4'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1028,      32'd0,          4'd6);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1036,      32'h0102_0304,  4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1036,      32'd0,          4'd9);

    $display("[TB] both enables, underflowed address");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd1040,      32'hA1B2_C3D4,  4'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1040,      32'd0,          4'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0,         32'h0BAD_CAFE,  4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0,         32'd0,          4'd11);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0,          4'd15);

    $display("[TB] reset during HI of a store");
    tbWb = 1'b0; tbMr = 1'b0; tbMw = 1'b1; tbAlu = 32'd1044; tbRm = 32'hCAFE_F00D; tbDest = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hi_addr", 32'(obsAddr), 32'({17'd5, 1'b1}));
    checkOutput("hi_we_n", 32'(obsWeN),  32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("hi_rst_ready", 32'(obsReady), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tbMw = 1'b0; tbAlu = 32'd0; tbRm = 32'd0; tbDest = 4'd0;
    checkOutput("post_rst_we_n",  32'(obsWeN),   32'd1);
    checkOutput("post_rst_ready", 32'(obsReady), 32'd1);
    checkAllZero("post_rst");
    expQ.delete();
    lastExp = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'd0, 4'd8);

    $display("[TB] SRAM_WAIT=3 instance");
    sel = 1'b1;
    rst = 1'b1;
    tbWb = 1'b0; tbMr = 1'b0; tbMw = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAllZero("w3_rst");
    lastExp = '0;
    resetRefMem();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1032,      32'd0,         4'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1048,      32'h5566_7788, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1048,      32'd0,         4'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
